// File: rtl/dot_product_accumulator_if.sv
// Element-stream, coefficient-write and result handshake bundle for the
// dot-product accumulator. The slave modport is the accumulator side.
interface dot_product_accumulator_if #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 12,
  parameter int ACC_WIDTH     = 2*DATA_WIDTH+ADDRESS_WIDTH
);
  logic                     start;
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     coef_we;
  logic [ADDRESS_WIDTH-1:0] coef_addr;
  logic [DATA_WIDTH-1:0]    coef_data;
  logic [ACC_WIDTH-1:0]     result;
  logic                     result_valid;
  logic                     result_ready;
  logic                     busy;
  logic [ADDRESS_WIDTH:0]   elem_count;

  modport master (
    output start, in_valid, in_data, coef_we, coef_addr, coef_data, result_ready,
    input  in_ready, result, result_valid, busy, elem_count
  );

  modport slave (
    input  start, in_valid, in_data, coef_we, coef_addr, coef_data, result_ready,
    output in_ready, result, result_valid, busy, elem_count
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Multiplies each streamed element by the stored coefficient of the same
// index and accumulates N = 2**ADDRESS_WIDTH products into one result,
// held on a valid/ready port until accepted.
//
// state | meaning
// IDLE  | coefficients writable, waiting for start
// ACCUM | accepting elements, accumulating products
// DONE  | result presented, waiting for result_ready
module dot_product_accumulator #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 12,
  parameter int ACC_WIDTH     = 2*DATA_WIDTH+ADDRESS_WIDTH
) (
  input  logic clk,
  input  logic rst,
  dot_product_accumulator_if.slave bus
);
  localparam int N = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] LAST_IDX = (ADDRESS_WIDTH+1)'(N-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [ACC_WIDTH-1:0]     r_acc;
  logic [ACC_WIDTH-1:0]     r_result;
  logic                     r_result_valid;
  logic                     r_in_ready;
  logic                     r_busy;
  logic [ADDRESS_WIDTH:0]   r_elem_count;
  logic [DATA_WIDTH-1:0]    r_coef [N];

  logic [2*DATA_WIDTH-1:0]  w_product;
  logic [ACC_WIDTH-1:0]     w_acc_next;
  logic                     w_accept;

  // Product of the incoming element and the coefficient for its position.
  always_comb begin
    w_product  = bus.in_data * r_coef[r_elem_count[ADDRESS_WIDTH-1:0]];
    w_acc_next = r_acc + ACC_WIDTH'(w_product);
    w_accept   = bus.in_valid && r_in_ready;
  end

  // Coefficient storage; only writable while idle so a pass sees a stable set.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.coef_we)
      r_coef[bus.coef_addr] <= bus.coef_data;
  end

  // Pass sequencing with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_elem_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc        <= '0;
            r_elem_count <= '0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc        <= w_acc_next;
            r_elem_count <= r_elem_count + 1'b1;
            if (r_elem_count == LAST_IDX) begin
              r_result       <= w_acc_next;
              r_result_valid <= 1'b1;
              r_in_ready     <= 1'b0;
              r_state        <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (r_result_valid && bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;
  assign bus.elem_count   = r_elem_count;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: table vectors, random
// passes against an arithmetic reference, and hand-written corner sequences.
module tb_dot_product_accumulator;
  localparam int AW = 3;
  localparam int DW = 12;
  localparam int AC = 2*DW+AW;
  localparam int N  = 2**AW;

  logic clk;
  logic rst;

  dot_product_accumulator_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(AC)) bus();

  dot_product_accumulator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(AC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] ref_coef [N];

  typedef struct packed {
    logic [1:0]           coef_mode; // 0: all ones, 1: all max, 2: coef=index
    logic [N-1:0][DW-1:0] data;
    logic [1:0]           gap_mode;  // 0: back-to-back, 1: alternate, 2: random
    logic [AC-1:0]        exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_coef(input int addr, input logic [DW-1:0] val);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(addr);
    bus.coef_data = val;
    ref_coef[addr] = val;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic load_mode(input logic [1:0] mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        2'd0:    write_coef(i, 12'd1);
        2'd1:    write_coef(i, 12'd4095);
        default: write_coef(i, DW'(i));
      endcase
    end
  endtask

  function automatic logic [AC-1:0] model(input logic [N-1:0][DW-1:0] d);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(d[i]) * longint'(ref_coef[i]);
    return AC'(s);
  endfunction

  // One full pass. Optional: coef write in the start cycle, start/coef_we
  // pulsed throughout ACCUM, and a held-off result_ready.
  task automatic do_pass(input string name, input logic [N-1:0][DW-1:0] d,
                         input int gap_mode, input int hold, input bit disturb,
                         input bit sw_en, input int sw_addr, input logic [DW-1:0] sw_data,
                         input logic [AC-1:0] exp);
    int  got;
    int  cyc;
    bit  take;
    bit  v;
    @(negedge clk);
    bus.start = 1'b1;
    if (sw_en) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = AW'(sw_addr);
      bus.coef_data = sw_data;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.coef_we = 1'b0;
    check({name, " in_ready_after_start"}, 64'(bus.in_ready), 64'd1);
    check({name, " busy_after_start"}, 64'(bus.busy), 64'd1);
    check({name, " count_after_start"}, 64'(bus.elem_count), 64'd0);
    got = 0;
    cyc = 0;
    while (got < N && cyc < 200) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_data  = d[got];
      if (disturb) begin
        bus.start     = 1'b1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = 12'd7;
      end
      check({name, " count_tracks"}, 64'(bus.elem_count), 64'(got));
      check({name, " no_early_valid"}, 64'(bus.result_valid), 64'd0);
      take = v && bus.in_ready;
      @(negedge clk);
      if (take) got++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.coef_we  = 1'b0;
    if (got < N) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, got, N);
    end
    check({name, " result_valid"}, 64'(bus.result_valid), 64'd1);
    check({name, " result"}, 64'(bus.result), 64'(exp));
    check({name, " elem_count"}, 64'(bus.elem_count), 64'(N));
    check({name, " in_ready_done"}, 64'(bus.in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({name, " hold_result"}, 64'(bus.result), 64'(exp));
      check({name, " hold_valid"}, 64'(bus.result_valid), 64'd1);
      check({name, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({name, " hold_count"}, 64'(bus.elem_count), 64'(N));
    end
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b1;
    if (hold > 0) bus.start = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check({name, " valid_drop"}, 64'(bus.result_valid), 64'd0);
    check({name, " idle_busy"}, 64'(bus.busy), 64'd0);
    check({name, " result_kept"}, 64'(bus.result), 64'(exp));
    @(negedge clk);
    check({name, " stays_idle"}, 64'(bus.busy), 64'd0);
  endtask

  logic [N-1:0][DW-1:0] dv;
  logic [AC-1:0]        e;
  logic [DW-1:0]        sw;

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.coef_we      = 1'b0;
    bus.coef_addr    = '0;
    bus.coef_data    = '0;
    bus.result_ready = 1'b0;

    for (int i = 0; i < N; i++) vecs[0].data[i] = DW'(i + 1);
    vecs[0].coef_mode = 2'd0; vecs[0].gap_mode = 2'd0; vecs[0].exp = AC'(36);
    for (int i = 0; i < N; i++) vecs[1].data[i] = 12'd4095;
    vecs[1].coef_mode = 2'd1; vecs[1].gap_mode = 2'd0; vecs[1].exp = AC'(134152200);
    for (int i = 0; i < N; i++) vecs[2].data[i] = 12'd2;
    vecs[2].coef_mode = 2'd2; vecs[2].gap_mode = 2'd1; vecs[2].exp = AC'(56);
    for (int i = 0; i < N; i++) vecs[3].data[i] = DW'(i + 1);
    vecs[3].coef_mode = 2'd2; vecs[3].gap_mode = 2'd2; vecs[3].exp = AC'(168);

    repeat (2) @(negedge clk);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset result_valid", 64'(bus.result_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset elem_count", 64'(bus.elem_count), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      load_mode(vecs[k].coef_mode);
      do_pass($sformatf("vec%0d", k), vecs[k].data, int'(vecs[k].gap_mode),
              (k == 0) ? 5 : 0, 1'b0, 1'b0, 0, '0, vecs[k].exp);
    end

    // start and coef_we held during ACCUM must not restart or alter coef[0]
    load_mode(2'd2);
    for (int i = 0; i < N; i++) dv[i] = 12'd5;
    do_pass("disturb", dv, 0, 0, 1'b1, 1'b0, 0, '0, AC'(140));
    for (int i = 0; i < N; i++) dv[i] = 12'd1;
    do_pass("disturb_after", dv, 0, 0, 1'b0, 1'b0, 0, '0, AC'(28));

    // random passes; coef 7 is written in the start cycle itself
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N - 1; i++) write_coef(i, DW'($urandom));
      sw = DW'($urandom);
      ref_coef[N-1] = sw;
      for (int i = 0; i < N; i++) dv[i] = DW'($urandom);
      e = model(dv);
      do_pass($sformatf("rand%0d", r), dv, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 1'b0, 1'b1, N - 1, sw, e);
    end

    // reset after three accepted elements aborts the pass
    load_mode(2'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_reset count", 64'(bus.elem_count), 64'd3);
    rst = 1'b1;
    #1;
    check("async result", 64'(bus.result), 64'd0);
    check("async result_valid", 64'(bus.result_valid), 64'd0);
    check("async in_ready", 64'(bus.in_ready), 64'd0);
    check("async busy", 64'(bus.busy), 64'd0);
    check("async elem_count", 64'(bus.elem_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    load_mode(2'd0);
    for (int i = 0; i < N; i++) dv[i] = 12'd1;
    do_pass("after_reset", dv, 0, 0, 1'b0, 1'b0, 0, '0, AC'(8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Consumes the element stream produced by the memory reader stage (one DATA_WIDTH element per accepted beat), multiplies each element by a locally stored coefficient of the same index, and accumulates the 2**ADDRESS_WIDTH products into one unsigned dot-product result. The result is presented on a valid/ready output port and held until it is accepted. The block sits directly downstream of the memory reader in the dot-product datapath. Coefficients are loaded through a simple write port while the block is idle.

## Interface
- ADDRESS_WIDTH, 3, log2 of vector length; N = 2**ADDRESS_WIDTH elements per pass
- DATA_WIDTH, 12, element and coefficient width (unsigned)
- ACC_WIDTH, 2*DATA_WIDTH+ADDRESS_WIDTH, result width; a full pass never overflows

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a pass; honoured only in IDLE
- in_valid  input  1  element present on in_data
- in_data  input  DATA_WIDTH  element from the memory reader stage
- in_ready  output  1  block accepts an element this cycle
- coef_we  input  1  coefficient write strobe; honoured only in IDLE
- coef_addr  input  ADDRESS_WIDTH  coefficient index
- coef_data  input  DATA_WIDTH  coefficient value
- result  output  ACC_WIDTH  dot product
- result_valid  output  1  result is valid
- result_ready  input  1  consumer accepts result
- busy  output  1  high in ACCUM and DONE
- elem_count  output  ADDRESS_WIDTH+1  elements accepted in the current pass

## Operation
- Reset (async, any state): state = IDLE; accumulator, result, and elem_count = 0; in_ready, result_valid, and busy = 0. Coefficient storage is not cleared; its contents are undefined until written.
- IDLE:
  - coef_we=1 writes coef[coef_addr] at the clock edge.
  - start=1 clears the accumulator and elem_count, then moves to ACCUM.
- ACCUM:
  - in_ready=1.
  - An element is accepted on a cycle where in_valid && in_ready. On acceptance: acc += in_data * coef[elem_count], and elem_count increments.
  - When the accepted element is the Nth (elem_count == N-1 before increment): result <= acc + product, result_valid <= 1, move to DONE.
- DONE:
  - in_ready=0. result and result_valid hold.
  - On result_valid && result_ready: result_valid <= 0, move to IDLE. result keeps its last value.
- start outside IDLE is ignored. coef_we outside IDLE is ignored; coefficients cannot change mid-pass.
- Arithmetic:
  - Products are unsigned, 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH.
  - No saturation is needed. The maximum sum N*(2**DATA_WIDTH-1)**2 fits in ACC_WIDTH.
- elem_count reaches N in DONE. It is cleared only by the next start or by reset.

## Timing
- start sampled in IDLE → in_ready=1 on the next cycle.
- Elements can be accepted back-to-back, one per cycle. A pass with continuous in_valid takes N cycles in ACCUM.
- result_valid rises the cycle after the Nth element is accepted, so latency from the last element to result is 1 cycle.
- in_valid gaps stall accumulation with no loss. Elements offered while in_ready=0 are not consumed; the upstream stage must hold them.
- result_ready may be high before result_valid. In that case the handshake completes on the first DONE cycle and IDLE is entered one cycle later.
- start asserted in the same cycle the DONE handshake completes is ignored, because the block is not yet in IDLE. start is honoured from the following cycle.
- A coef write and start in the same IDLE cycle: the write takes effect and is visible to the pass.
- Reset mid-ACCUM or mid-DONE aborts the pass immediately. No result is produced.

## Test plan
- Write coef[i]=1 for all i. Start, then stream in_data 1..8 back-to-back → result=36, result_valid one cycle after the 8th beat, elem_count=8.
- Write coef[i]=4095 for all i. Stream 4095 ×8 → result=134152200 with no overflow (ACC_WIDTH=27).
- Write coef[i]=i. Stream 2 ×8, with in_valid low on alternate cycles → result=56, and exactly 8 beats are accepted.
- Complete a pass, then hold result_ready=0 for 5 cycles → result and result_valid stay stable and in_ready=0 throughout. Raise result_ready → result_valid drops, and IDLE is entered the next cycle.
- During ACCUM, pulse start and apply coef_we (addr 0, data 7) → no restart and no coef change; the pass result matches the original coefficients.
- Assert rst after 3 elements are accepted → all outputs return to 0 asynchronously. A new start plus 8 elements of value 1 with coef=1 → result=8.
